// File: rtl/byte_strip.sv
// Transmit-side byte striper: spreads a serial byte stream round-robin over four lanes
// and presents each completed (or flushed, padded) group in parallel with a one-cycle strobe.
module byte_strip #(
    parameter logic [7:0] PAD_BYTE = 8'hBC,
    parameter logic       PAD_K    = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] D,
    input  logic       DK,
    input  logic       VALID_IN,
    input  logic       FLUSH,
    output logic [7:0] LANE0,
    output logic [7:0] LANE1,
    output logic [7:0] LANE2,
    output logic [7:0] LANE3,
    output logic       DK_0,
    output logic       DK_1,
    output logic       DK_2,
    output logic       DK_3,
    output logic       VALID_OUT,
    output logic [2:0] FILL
);

    logic [1:0] ptr;
    logic [8:0] slot [0:3];
    logic [8:0] grp  [0:3];
    logic       emit;

    // A group closes on the 4th byte, or on FLUSH whenever anything is (or is being) buffered.
    always_comb begin
        emit = (VALID_IN && ptr == 2'd3) || (FLUSH && (VALID_IN || ptr != 2'd0));
        for (int k = 0; k < 4; k++) begin
            if (2'(k) < ptr)
                grp[k] = slot[k];
            else if (VALID_IN && 2'(k) == ptr)
                grp[k] = {DK, D};
            else
                grp[k] = {PAD_K, PAD_BYTE};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr       <= 2'd0;
            VALID_OUT <= 1'b0;
            LANE0     <= 8'h00;
            LANE1     <= 8'h00;
            LANE2     <= 8'h00;
            LANE3     <= 8'h00;
            DK_0      <= 1'b0;
            DK_1      <= 1'b0;
            DK_2      <= 1'b0;
            DK_3      <= 1'b0;
            for (int k = 0; k < 4; k++)
                slot[k] <= 9'h000;
        end else begin
            VALID_OUT <= emit;
            if (emit) begin
                ptr           <= 2'd0;
                {DK_0, LANE0} <= grp[0];
                {DK_1, LANE1} <= grp[1];
                {DK_2, LANE2} <= grp[2];
                {DK_3, LANE3} <= grp[3];
            end else if (VALID_IN) begin
                slot[ptr] <= {DK, D};
                ptr       <= ptr + 2'd1;
            end
        end
    end

    assign FILL = {1'b0, ptr};

endmodule

// File: doc/byte_strip.md
Name: byte_strip

Overview:
- Transmit-side byte striper for the 4-lane link.
- Takes a serial byte stream (D + K flag) from the framing logic.
- Distributes consecutive bytes round-robin onto LANE0..LANE3 and presents each completed group of 4 in parallel, with a one-cycle VALID_OUT strobe.
- Sits directly upstream of the lane serializers; its lane outputs map 1:1 onto the lane inputs of the receive-side unstriper in loopback.

Parameters:
PAD_BYTE, 8'hBC, byte inserted into unfilled lanes on FLUSH (K28.5 COM).
PAD_K, 1'b1, K flag accompanying PAD_BYTE.

Ports:
CLK  input  1  single clock; all logic on rising edge.
RESET  input  1  synchronous, active-high reset.
D  input  8  incoming byte.
DK  input  1  K-character flag for D.
VALID_IN  input  1  D/DK valid this cycle.
FLUSH  input  1  close the current partial group, padding the remaining lanes.
LANE0..LANE3  output  8 each  registered lane bytes.
DK_0..DK_3  output  1 each  registered lane K flags.
VALID_OUT  output  1  one-cycle strobe: lanes hold a new complete group.
FILL  output  3  bytes currently buffered in the partial group (0..3).

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RESET), sampled on the CLK rising edge.
- Reset values: LANE0..3=8'h00, DK_0..3=0, VALID_OUT=0, FILL=0, lane pointer PTR=0, shadow slots cleared. Reset dominates all other inputs.
- Internal state:
  - 2-bit PTR, the next slot to fill (0..3; wraps 3->0).
  - Four 9-bit shadow slots {K, byte}.
- FILL equals PTR.
- Accept: on VALID_IN=1, slot[PTR] <= {DK,D}; PTR <= PTR+1.
- Group complete: when VALID_IN=1 with PTR=3, on the same edge:
  - LANEk/DK_k <= slot k for k=0..2, and LANE3/DK_3 <= {D,DK}.
  - VALID_OUT <= 1 next cycle; PTR wraps to 0.
  - Latency: 1 clock from the 4th byte's edge to VALID_OUT high.
- VALID_OUT is high for exactly one cycle per group. Lane outputs hold their value until the next group; they are never updated without VALID_OUT.
- FLUSH, partial group (FLUSH=1, VALID_IN=0, PTR!=0): slots PTR..3 are emitted as {PAD_K,PAD_BYTE}, lanes update, VALID_OUT pulses, PTR <= 0.
- FLUSH with VALID_IN=1 in the same cycle:
  - The byte is written to slot PTR first, then slots PTR+1..3 are padded.
  - The group is emitted and PTR <= 0.
  - If PTR was 3, this is a normal completion with no padding.
- FLUSH with PTR=0 and VALID_IN=0: no-op (no VALID_OUT, lanes unchanged).
- Back-to-back: VALID_IN may be high every cycle. Groups emit every 4 cycles with no bubble, and the first byte of the next group is accepted on the same edge the previous group is emitted.
- Idle: VALID_IN=0 and FLUSH=0 leaves all state unchanged; a partial group waits indefinitely.
- Reset mid-group discards buffered bytes. No VALID_OUT is produced for them, and the next accepted byte goes to LANE0.
- Lane order is fixed: the 1st byte of a group goes to LANE0, the 4th to LANE3. DK travels with its byte unmodified.
- No backpressure: the block always accepts and there is no ready output.

Test Plan:
- Reset: assert RESET 2 cycles with VALID_IN=1, D=8'hFF -> all LANEx=0, DK_x=0, VALID_OUT=0, FILL=0 throughout and one cycle after release.
- Single group: D=8'h11,8'h22,8'h33,8'h44 on 4 consecutive cycles, DK=0 -> one cycle after the 4th byte, LANE0..3=11,22,33,44 with VALID_OUT=1 for 1 cycle; FILL sequence 1,2,3,0.
- Streaming with K: 12 consecutive bytes 8'h00..8'h0B, DK=1 on byte 8'h04 only -> VALID_OUT pulses every 4th cycle (3 pulses); the second group has LANE0=8'h04 with DK_0=1 and all other DK flags 0.
- Gapped input: 8'hA1, idle 3 cycles, 8'hA2, 8'hA3, idle, 8'hA4 -> single VALID_OUT after 8'hA4 with lanes A1,A2,A3,A4; lanes unchanged and VALID_OUT=0 while waiting.
- Flush:
  - 8'h55,8'h66 then FLUSH alone -> LANE0..3=55,66,BC,BC, DK=0,0,1,1, VALID_OUT pulse, FILL=0.
  - FLUSH at FILL=0 -> no pulse.
  - FLUSH together with the 3rd byte 8'h77 (after 8'h55,8'h66) -> 55,66,77,BC.
- Reset mid-group: 8'h01,8'h02, RESET 1 cycle, then 8'hC0..8'hC3 -> only one VALID_OUT, with lanes C0,C1,C2,C3.
